// File: rtl/m41_scan_ctrl.sv
// Scan controller for the m41 4:1 mux: steps S through 0..3, dwells DWELL cycles per
// channel and publishes the captured Y bits as a 4-bit snapshot.
// Optional build macro M41_SCAN_CONTINUOUS_EN: a start seen in DONE re-enters SCAN directly.
module m41_scan_ctrl #(
  parameter int DWELL   = 2,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Y,
  output logic [1:0] S,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);
  localparam logic [1:0]         CH_LAST  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         s_q, s_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         result_q, result_d;
  logic               valid_q, valid_d;

  logic               capture;
  logic [3:0]         shadow_cap;

  assign capture = (state_q == ST_SCAN) && (cnt_q == CNT_LAST);

  // Shadow image with the current channel's bit replaced by Y.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cap
      assign shadow_cap[gi] = (s_q == 2'(gi)) ? Y : shadow_q[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    result_d = result_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE: begin
        s_d   = 2'd0;
        cnt_d = '0;
        if (start) begin
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (capture) begin
          cnt_d    = '0;
          shadow_d = shadow_cap;
          if (s_q == CH_LAST) begin
            // Publish the whole snapshot at once, including the bit captured now.
            state_d  = ST_DONE;
            s_d      = 2'd0;
            result_d = shadow_cap;
            valid_d  = 1'b1;
          end else begin
            s_d = s_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        s_d   = 2'd0;
        cnt_d = '0;
`ifdef M41_SCAN_CONTINUOUS_EN
        if (start) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      s_q      <= 2'd0;
      shadow_q <= 4'b0000;
      result_q <= 4'b0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign S      = s_q;
  assign busy   = (state_q == ST_SCAN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_m41_scan_ctrl.sv
// Directed bench for m41_scan_ctrl: two instances (DWELL=2 and DWELL=1), each feeding a
// behavioural m41 mux; expected snapshots go through a scoreboard queue.
module tb_m41_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] in_a, in_b;
  logic       y_a, y_b;
  logic [1:0] s_a, s_b;
  logic       busy_a, busy_b, done_a, done_b, valid_a, valid_b;
  logic [3:0] result_a, result_b;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] sb_q[$];

`ifdef M41_SCAN_CONTINUOUS_EN
  localparam int HELD_PERIOD = 9;
`else
  localparam int HELD_PERIOD = 10;
`endif

  always #5 clk = ~clk;

  // Behavioural m41 mux in front of each controller.
  assign y_a = in_a[s_a];
  assign y_b = in_b[s_b];

  m41_scan_ctrl #(.DWELL(2), .DWELL_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .Y(y_a), .S(s_a),
    .busy(busy_a), .done(done_a), .result(result_a), .valid(valid_a)
  );

  m41_scan_ctrl #(.DWELL(1), .DWELL_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .Y(y_b), .S(s_b),
    .busy(busy_b), .done(done_b), .result(result_b), .valid(valid_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int dut, input logic v);
    if (dut == 0) start_a = v; else start_b = v;
  endtask

  function automatic logic [7:0] get_sig(input int dut, input int which);
    case (which)
      0: return (dut == 0) ? {6'd0, s_a}      : {6'd0, s_b};
      1: return (dut == 0) ? {7'd0, busy_a}   : {7'd0, busy_b};
      2: return (dut == 0) ? {7'd0, done_a}   : {7'd0, done_b};
      3: return (dut == 0) ? {4'd0, result_a} : {4'd0, result_b};
      default: return (dut == 0) ? {7'd0, valid_a} : {7'd0, valid_b};
    endcase
  endfunction

  // One full scan. restart_at: cycle index at which start is re-pulsed mid-scan (0 = none).
  // flip_ch: channel whose input is inverted right after it was captured (-1 = none).
  task automatic run_scan(input int dut, input int d, input logic [3:0] ins,
                          input int restart_at, input int flip_ch);
    logic [3:0] exp_res;
    if (dut == 0) in_a = ins; else in_b = ins;
    sb_q.push_back(ins);
    set_start(dut, 1'b1);
    for (int c = 0; c <= 4 * d; c++) begin
      tick();
      set_start(dut, (c + 1 == restart_at) ? 1'b1 : 1'b0);
      if (c < 4 * d) begin
        chk($sformatf("dut%0d_busy_c%0d", dut, c), get_sig(dut, 1), 8'd1);
        chk($sformatf("dut%0d_done_c%0d", dut, c), get_sig(dut, 2), 8'd0);
        chk($sformatf("dut%0d_S_c%0d", dut, c), get_sig(dut, 0), 8'(c / d));
        if (flip_ch >= 0 && c == (flip_ch + 1) * d) begin
          if (dut == 0) in_a[flip_ch] = ~in_a[flip_ch];
          else          in_b[flip_ch] = ~in_b[flip_ch];
        end
      end else begin
        chk($sformatf("dut%0d_done_end", dut), get_sig(dut, 2), 8'd1);
        chk($sformatf("dut%0d_busy_end", dut), get_sig(dut, 1), 8'd0);
        chk($sformatf("dut%0d_S_end", dut), get_sig(dut, 0), 8'd0);
        chk($sformatf("dut%0d_valid_end", dut), get_sig(dut, 4), 8'd1);
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
          exp_res = sb_q.pop_front();
          chk($sformatf("dut%0d_result", dut), get_sig(dut, 3), {4'd0, exp_res});
        end
      end
    end
    set_start(dut, 1'b0);
    tick();
    chk($sformatf("dut%0d_done_after", dut), get_sig(dut, 2), 8'd0);
    tick();
    chk($sformatf("dut%0d_idle_busy", dut), get_sig(dut, 1), 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] exp_res;
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; in_a = 4'hF; in_b = 4'hF;

    // Reset held two cycles with start high.
    tick(); tick();
    for (int dut = 0; dut < 2; dut++) begin
      chk($sformatf("rst_dut%0d_S", dut), get_sig(dut, 0), 8'd0);
      chk($sformatf("rst_dut%0d_busy", dut), get_sig(dut, 1), 8'd0);
      chk($sformatf("rst_dut%0d_done", dut), get_sig(dut, 2), 8'd0);
      chk($sformatf("rst_dut%0d_result", dut), get_sig(dut, 3), 8'd0);
      chk($sformatf("rst_dut%0d_valid", dut), get_sig(dut, 4), 8'd0);
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tick();
    $display("step reset: done");

    // Basic scan: i0=1 i1=0 i2=1 i3=1 -> 4'b1101.
    run_scan(0, 2, 4'b1101, 0, -1);
    $display("step basic scan dwell=2: result=%b", result_a);

    // start re-pulsed mid-scan, channel 1 input flipped after its capture.
    run_scan(0, 2, 4'b0110, 3, 1);
    $display("step restart/flip scan: result=%b", result_a);

    // Reset while S=2: everything back to reset values, partial scan dropped.
    in_a = 4'b1001;
    sb_q.push_back(in_a);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    chk("midrst_S_before", {6'd0, s_a}, 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("midrst_S", {6'd0, s_a}, 8'd0);
    chk("midrst_busy", {7'd0, busy_a}, 8'd0);
    chk("midrst_done", {7'd0, done_a}, 8'd0);
    chk("midrst_result", {4'd0, result_a}, 8'd0);
    chk("midrst_valid", {7'd0, valid_a}, 8'd0);
    tick();
    $display("step reset mid-scan: done");
    run_scan(0, 2, 4'b1010, 0, -1);
    $display("step scan after reset: result=%b", result_a);

    // DWELL=1 instance (its earlier reset also cleared it).
    run_scan(1, 1, 4'b0110, 0, -1);
    $display("step dwell=1 scan: result=%b", result_b);

    // start held high: measure done-to-done period, i0 toggled between scans.
    in_a = 4'b0011;
    sb_q.push_back(in_a);
    start_a = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_a && n < 40);
    chk("held_first_done", {7'd0, done_a}, 8'd1);
    exp_res = (sb_q.size() != 0) ? sb_q.pop_front() : 4'hx;
    chk("held_first_result", {4'd0, result_a}, {4'd0, exp_res});
    in_a[0] = ~in_a[0];
    sb_q.push_back(in_a);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_a && n < 40);
    start_a = 1'b0;
    chk("held_period", 8'(n), 8'(HELD_PERIOD));
    exp_res = (sb_q.size() != 0) ? sb_q.pop_front() : 4'hx;
    chk("held_second_result", {4'd0, result_a}, {4'd0, exp_res});
    tick();
    tick();
    chk("held_end_busy", {7'd0, busy_a}, 8'd0);
    chk("held_end_result_hold", {4'd0, result_a}, {4'd0, exp_res});
    $display("step held start: period=%0d result=%b", n, result_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/m41_scan_ctrl.md
# m41_scan_ctrl

Sequential scan controller for the `m41` 4:1 multiplexer. It drives the mux select `S`, waits a programmable dwell time on each channel, and captures the mux output `Y` for channels 0 to 3 into a 4-bit snapshot. It sits directly upstream of `m41`, driving `S`, and directly downstream of it, consuming `Y`. This turns the combinational mux into a polled 4-input sampler for the rest of the design.

## Interface
Parameters:
- `DWELL`, default 2: cycles spent on each channel before `Y` is captured. Legal range is 1 to 255.
- `DWELL_W`, default 8: width of the dwell counter.

Ports:
- `clk`  in  1  single clock; every register is updated on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  requests a scan; sampled only in IDLE (and in DONE when `M41_SCAN_CONTINUOUS_EN` is defined).
- `Y`  in  1  output of the `m41` mux.
- `S`  out  2  select driven to the `m41` mux.
- `busy`  out  1  high while the FSM is in SCAN.
- `done`  out  1  one-cycle pulse when a scan completes.
- `result`  out  4  snapshot; bit k holds the value of `Y` captured while `S`=k.
- `valid`  out  1  sticky; set at the first `done` and held until `rst`.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `S`=0, dwell counter `cnt`=0.
  - If `start`=1, go to SCAN.
- SCAN:
  - `cnt` increments every cycle.
  - When `cnt`==`DWELL`-1: capture `shadow[S]` <= `Y`, clear `cnt` to 0.
  - If `S`==3 on that capture, go to DONE with `S` returned to 0. Otherwise `S` <= `S`+1 and stay in SCAN.
- DONE:
  - Lasts one cycle; `done`=1 and `busy`=0.
  - The full 4-bit shadow (including the bit captured on the entry edge) is already in `result`. `valid` is set.
  - Then go to IDLE. Continuous mode (Configuration) changes this transition.
- `result` is updated only on the edge that enters DONE, never partially mid-scan. Between scans it holds its last value.
- `start` is ignored while in SCAN. A scan cannot be aborted except by `rst`.
- `cnt` is `DWELL_W` bits wide and never reaches `DWELL`, so it never wraps.
- `DWELL`=1: one capture per cycle; a scan takes 4 SCAN cycles.

## Timing
- Reset values: `S`=0, `busy`=0, `done`=0, `result`=4'b0000, `valid`=0; FSM in IDLE, `cnt`=0, `shadow`=0.
- `rst` wins over every other input in the same cycle.
- `rst` mid-scan: on the next edge the FSM is in IDLE, all outputs are at reset values, and the partial shadow is discarded.
- `start` high at edge E (in IDLE):
  - `busy`=1 and `S`=0 from E+1.
  - `S` steps at E+`DWELL`, E+2·`DWELL` and E+3·`DWELL`.
  - The last capture happens at edge E+4·`DWELL`.
  - `done`=1 during cycle E+4·`DWELL`..E+4·`DWELL`+1.
  - Latency from `start` to `done` is 4·`DWELL` cycles; `busy` is high for exactly 4·`DWELL` cycles.
- `Y` is sampled at the capturing edge. The mux is combinational, so `Y` reflects the current `S`; `DWELL`≥2 gives one full settle cycle.
- `S` changes only on clock edges and is registered, so it is glitch-free.

## Configuration
- `M41_SCAN_CONTINUOUS_EN` defined:
  - In DONE, if `start`=1, go directly to SCAN with `S`=0 and `cnt`=0 (no IDLE cycle). Otherwise go to IDLE.
  - A held-high `start` therefore gives back-to-back scans with a period of 4·`DWELL`+1 cycles.
- Not defined: DONE always goes to IDLE and `start` is ignored in DONE. Back-to-back scans need `start` in IDLE, giving a minimum period of 4·`DWELL`+2 cycles.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → `S`=0, `busy`=0, `done`=0, `result`=0, `valid`=0.
- Basic scan, `DWELL`=2, mux inputs i0=1, i1=0, i2=1, i3=1: pulse `start` → `S` sequence 0,0,1,1,2,2,3,3; `done` 8 cycles after `start`; `result`=4'b1101; `valid`=1.
- `start` re-pulsed mid-scan, and inputs changed after their channel was captured → scan length unchanged; `result` reflects the captured values only; no second scan is started.
- `rst` asserted during `S`=2 → all outputs at reset values next cycle; the previous `result` is cleared; a following `start` gives a complete, correct scan.
- `DWELL`=1: `start` → `S`=0,1,2,3 on consecutive cycles; `done` 4 cycles after `start`.
- `M41_SCAN_CONTINUOUS_EN`, `start` held high, `DWELL`=2: `done` pulses every 9 cycles; toggling i0 between scans is reflected in `result[0]` of the next scan.
